// File: rtl/fsm_rd_responder_pkg.sv
// rtl/fsm_rd_responder_pkg.sv - state encodings, default widths and stats limits for fsm_rd_responder
package fsm_resp_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_BUSY = 2'b01,
    R_DONE = 2'b10
  } resp_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int AW_DEF     = 4;
  localparam int WAIT_W_DEF = 3;

  localparam logic [15:0] XFER_SAT  = 16'hFFFF;
  localparam logic [7:0]  ABORT_SAT = 8'hFF;

endpackage

// File: rtl/fsm_rd_responder_if.sv
// rtl/fsm_rd_responder_if.sv - read handshake, config and buffer write port bundle
interface fsm_rd_responder_if
  import fsm_resp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = AW_DEF,
  parameter int WAIT_W = WAIT_W_DEF
);
  logic              rd;
  logic [WAIT_W-1:0] cfg_wait;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ws;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [AW-1:0]     rptr;

  modport master (
    output rd, cfg_wait, wr_en, wr_addr, wr_data,
    input  ws, rdata, rvalid, rptr
  );

  modport slave (
    input  rd, cfg_wait, wr_en, wr_addr, wr_data,
    output ws, rdata, rvalid, rptr
  );
endinterface

// File: rtl/fsm_rd_responder_wait_cnt.sv
// rtl/fsm_rd_responder_wait_cnt.sv - loadable wait-state down-counter with zero flag
module resp_wait_cnt
  import fsm_resp_pkg::*;
#(
  parameter int WAIT_W = WAIT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/fsm_rd_responder.sv
// rtl/fsm_rd_responder.sv - go/rd/ws/ds read target with wait states and a wrapping word buffer
// Optional RESP_STATS_EN adds saturating transfer/abort counters.
module fsm_rd_responder
  import fsm_resp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = AW_DEF,
  parameter int WAIT_W = WAIT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fsm_rd_responder_if.slave    bus
`ifdef RESP_STATS_EN
  ,
  output logic [15:0]          xfer_cnt,
  output logic [7:0]           abort_cnt
`endif
);
  resp_state_t       state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [DATA_W-1:0] mem_q [DEPTH];

  resp_wait_cnt #(.WAIT_W(WAIT_W)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (bus.cfg_wait),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rptr_d   = rptr_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (bus.rd) begin
          cnt_load = 1'b1;
          state_d  = R_BUSY;
        end
      end
      R_BUSY: begin
        if (!bus.rd) begin
          state_d = R_IDLE;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          // Buffer read sees the pre-edge word, so a same-cycle write is not bypassed.
          rdata_d  = mem_q[rptr_q];
          rvalid_d = 1'b1;
          rptr_d   = rptr_q + AW'(1);
          state_d  = R_DONE;
        end
      end
      R_DONE:  state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= R_IDLE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rptr_q   <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ws depends only on flops so the initiator never sees a loop through rd.
  assign bus.ws     = (state_q == R_BUSY) && !cnt_zero;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rptr   = rptr_q;

`ifdef RESP_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;

  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    abort_cnt_d = abort_cnt_q;
    if (rvalid_d && (xfer_cnt_q != XFER_SAT)) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
    if ((state_q == R_BUSY) && !bus.rd && (abort_cnt_q != ABORT_SAT)) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif
endmodule
